// File: rtl/master_slave_link_if.sv
// master_slave_link_if
//   Serial system-bus wires between the master port and the slave port of
//   master_slave_link. Both ports of the link connect to the same instance,
//   so each one drives its own half of the bus and observes the other half.
//
//   mode          master -> slave  bus direction, 1 write / 0 read
//   wr_bus        master -> slave  serial address/write-data bit, LSB first
//   master_valid  master -> slave  request/address/data phase active
//   master_ready  master -> slave  master waiting for read data
//   rd_bus        slave -> master  serial read-data bit, LSB first
//   slave_ready   slave -> master  slave idle, can accept a request
//   slave_valid   slave -> master  read-data phase active
interface master_slave_link_if;
  logic mode;
  logic wr_bus;
  logic rd_bus;
  logic master_valid;
  logic slave_ready;
  logic slave_valid;
  logic master_ready;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  rd_bus, slave_ready, slave_valid
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output rd_bus, slave_ready, slave_valid
  );
endinterface

// File: rtl/master_slave_link.sv
// master_slave_link
//   Point-to-point serial link: a master port turns parallel commands into a
//   serial request (16 address bits, then 8 write-data bits for a write), and
//   a slave port owning a byte memory answers reads with 8 serial data bits.
//
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   m_start, m_mode     command request level; 1 = write, 0 = read
//   m_addr, m_wr_data   command address and write byte
//   m_rd_data, m_wr_en  last read byte, high while a read result is presented
//   m_bus               master half of the serial bus
//   s_bus               slave half of the serial bus (same bus instance)
module master_slave_link #(
  parameter int MEM_ADDR_W = 12
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       m_start,
  input  logic                       m_mode,
  input  logic [15:0]                m_addr,
  input  logic [7:0]                 m_wr_data,
  output logic [7:0]                 m_rd_data,
  output logic                       m_wr_en,
  master_slave_link_if.master        m_bus,
  master_slave_link_if.slave         s_bus
);

  typedef enum logic [2:0] {
    M_IDLE, M_REQ, M_ADDR, M_WDATA, M_RWAIT, M_RDATA, M_HOLD
  } m_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RLOAD, S_RDATA
  } s_state_t;

  // ---------------- master port ----------------
  m_state_t    m_state, m_nxt;
  logic [3:0]  m_cnt;
  logic        lat_mode;
  logic [15:0] lat_addr;
  logic [7:0]  lat_data;
  logic [6:0]  rx_sh;
  logic        m_accept;

  // A command is taken from IDLE or from HOLD whenever the FSM heads to REQ.
  assign m_accept = (m_nxt == M_REQ) && (m_state != M_REQ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) m_state <= M_IDLE;
    else       m_state <= m_nxt;
  end

  always_comb begin
    m_nxt               = m_state;
    m_bus.mode          = 1'b0;
    m_bus.wr_bus        = 1'b0;
    m_bus.master_valid  = 1'b0;
    m_bus.master_ready  = 1'b0;
    case (m_state)
      M_IDLE: if (m_start) m_nxt = M_REQ;
      M_REQ: begin
        m_bus.master_valid = 1'b1;
        m_bus.mode         = lat_mode;
        if (m_bus.slave_ready) m_nxt = M_ADDR;
      end
      M_ADDR: begin
        m_bus.master_valid = 1'b1;
        m_bus.mode         = lat_mode;
        m_bus.wr_bus       = lat_addr[m_cnt];
        if (m_cnt == 4'd15) m_nxt = lat_mode ? M_WDATA : M_RWAIT;
      end
      M_WDATA: begin
        m_bus.master_valid = 1'b1;
        m_bus.mode         = lat_mode;
        m_bus.wr_bus       = lat_data[m_cnt[2:0]];
        if (m_cnt == 4'd7) m_nxt = M_HOLD;
      end
      M_RWAIT: begin
        m_bus.master_ready = 1'b1;
        if (m_bus.slave_valid) m_nxt = M_RDATA;
      end
      M_RDATA: begin
        m_bus.master_ready = 1'b1;
        if (m_bus.slave_valid && m_cnt == 4'd7) m_nxt = M_HOLD;
      end
      M_HOLD: begin
        // A held-high request of the same kind is never re-served; only a
        // mode change counts as a new command.
        if (!m_start)                 m_nxt = M_IDLE;
        else if (m_mode != lat_mode)  m_nxt = M_REQ;
      end
      default: m_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt     <= 4'd0;
      lat_mode  <= 1'b0;
      m_wr_en   <= 1'b0;
      m_rd_data <= 8'h00;
    end else begin
      if (m_accept) lat_mode <= m_mode;
      if (m_state == M_HOLD && m_nxt != M_HOLD) m_wr_en <= 1'b0;
      // The counter wraps 15 -> 0 leaving ADDR, so WDATA/RWAIT start at 0.
      case (m_state)
        M_REQ:            m_cnt <= 4'd0;
        M_ADDR, M_WDATA:  m_cnt <= m_cnt + 4'd1;
        M_RWAIT, M_RDATA: if (m_bus.slave_valid) m_cnt <= m_cnt + 4'd1;
        default: ;
      endcase
      if (m_state == M_RDATA && m_bus.slave_valid && m_cnt == 4'd7) begin
        m_rd_data <= {m_bus.rd_bus, rx_sh};
        m_wr_en   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (m_accept) begin
      lat_addr <= m_addr;
      lat_data <= m_wr_data;
    end
    if ((m_state == M_RWAIT || m_state == M_RDATA) && m_bus.slave_valid)
      rx_sh <= {m_bus.rd_bus, rx_sh[6:1]};
  end

  // ---------------- slave port ----------------
  s_state_t              s_state, s_nxt;
  logic [3:0]            s_cnt;
  logic                  s_mode;
  logic [MEM_ADDR_W-1:0] s_addr;
  logic [6:0]            s_data;
  logic [7:0]            s_sh;
  logic [7:0]            mem [0:(1<<MEM_ADDR_W)-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) s_state <= S_IDLE;
    else       s_state <= s_nxt;
  end

  always_comb begin
    s_nxt             = s_state;
    s_bus.slave_ready = 1'b0;
    s_bus.slave_valid = 1'b0;
    s_bus.rd_bus      = 1'b0;
    case (s_state)
      S_IDLE: begin
        s_bus.slave_ready = 1'b1;
        if (s_bus.master_valid) s_nxt = S_ADDR;
      end
      S_ADDR:  if (s_cnt == 4'd15) s_nxt = s_mode ? S_WDATA : S_RLOAD;
      S_WDATA: if (s_cnt == 4'd7) s_nxt = S_IDLE;
      S_RLOAD: s_nxt = S_RDATA;
      S_RDATA: begin
        s_bus.slave_valid = 1'b1;
        s_bus.rd_bus      = s_sh[s_cnt[2:0]];
        if (s_bus.master_ready && s_cnt == 4'd7) s_nxt = S_IDLE;
      end
      default: s_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_cnt  <= 4'd0;
      s_mode <= 1'b0;
    end else begin
      case (s_state)
        S_IDLE: if (s_bus.master_valid) begin
          s_mode <= s_bus.mode;
          s_cnt  <= 4'd0;
        end
        S_ADDR, S_WDATA: s_cnt <= s_cnt + 4'd1;
        S_RLOAD:         s_cnt <= 4'd0;
        S_RDATA:         if (s_bus.master_ready) s_cnt <= s_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  // Only the low MEM_ADDR_W address bits are kept; the rest pass by unused.
  // The memory is written only on the edge sampling data bit 7, so an
  // aborted write leaves it untouched.
  always_ff @(posedge clk) begin
    case (s_state)
      S_ADDR:
        if ({1'b0, s_cnt} < 5'(MEM_ADDR_W)) s_addr[s_cnt] <= s_bus.wr_bus;
      S_WDATA: begin
        s_data <= {s_bus.wr_bus, s_data[6:1]};
        if (s_cnt == 4'd7) mem[s_addr] <= {s_bus.wr_bus, s_data};
      end
      S_RLOAD: s_sh <= mem[s_addr];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_master_slave_link.sv
// tb_master_slave_link
//   Directed bench for master_slave_link: reset values, write/read transfers
//   with serial bit-order and phase-length checks, HOLD behaviour, address
//   aliasing, a randomised write/read loop and a mid-transfer reset.
module tb_master_slave_link;
  logic        clk = 1'b0;
  logic        rstn;
  logic        m_start = 1'b0;
  logic        m_mode = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [7:0]  m_wr_data = 8'h0;
  logic [7:0]  m_rd_data;
  logic        m_wr_en;
  logic [7:0]  last_rd;
  int          n_checks = 0;
  int          n_fail = 0;

  master_slave_link_if bus();

  master_slave_link #(.MEM_ADDR_W(12)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_start   (m_start),
    .m_mode    (m_mode),
    .m_addr    (m_addr),
    .m_wr_data (m_wr_data),
    .m_rd_data (m_rd_data),
    .m_wr_en   (m_wr_en),
    .m_bus     (bus),
    .s_bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mode"},         32'(bus.mode),         32'(0));
    check({tag, "_wr_bus"},       32'(bus.wr_bus),       32'(0));
    check({tag, "_rd_bus"},       32'(bus.rd_bus),       32'(0));
    check({tag, "_master_valid"}, 32'(bus.master_valid), 32'(0));
    check({tag, "_slave_valid"},  32'(bus.slave_valid),  32'(0));
    check({tag, "_master_ready"}, 32'(bus.master_ready), 32'(0));
    check({tag, "_slave_ready"},  32'(bus.slave_ready),  32'(1));
    check({tag, "_m_wr_en"},      32'(m_wr_en),          32'(0));
    check({tag, "_m_rd_data"},    32'(m_rd_data),        32'(0));
  endtask

  // Samples are taken on falling edges; c = 0 is the sample after E0.
  task automatic run_write(input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    int         mv_cnt = 0;
    int         sv_cnt = 0;
    logic [15:0] ga = '0;
    logic [7:0]  gd = '0;
    logic        we_seen = 1'b0;
    @(negedge clk);
    m_start = 1'b1; m_mode = 1'b1; m_addr = a; m_wr_data = d;
    @(negedge clk);
    m_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) check("wr_en_clear", 32'(m_wr_en), 32'(0));
      if (bus.master_valid) begin
        mv_cnt++;
        if (c >= 1 && c <= 16) ga[c-1] = bus.wr_bus;
        if (c >= 17 && c <= 24) gd[c-17] = bus.wr_bus;
      end
      if (bus.slave_valid) sv_cnt++;
      if (m_wr_en) we_seen = 1'b1;
      @(negedge clk);
    end
    check("wr_mv_cycles", 32'(mv_cnt), 32'(25));
    check("wr_addr_bits", 32'(ga), 32'(a));
    check("wr_data_bits", 32'(gd), 32'(d));
    check("wr_sv_cycles", 32'(sv_cnt), 32'(0));
    check("wr_en_low", 32'(we_seen), 32'(0));
    check("wr_rd_held", 32'(m_rd_data), 32'(exp_rd));
  endtask

  task automatic run_read(input logic [15:0] a, input logic [7:0] exp, input logic hold);
    int        mv_cnt = 0;
    int        sv_cnt = 0;
    logic [7:0] gr = '0;
    @(negedge clk);
    m_start = 1'b1; m_mode = 1'b0; m_addr = a;
    @(negedge clk);
    if (!hold) m_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.master_valid) mv_cnt++;
      if (bus.slave_valid) begin
        if (sv_cnt < 8) gr[sv_cnt] = bus.rd_bus;
        sv_cnt++;
      end
      if (c == 25) check("rd_en_before", 32'(m_wr_en), 32'(0));
      if (c == 26) begin
        check("rd_en_rise", 32'(m_wr_en), 32'(1));
        check("rd_data", 32'(m_rd_data), 32'(exp));
      end
      if (c == 27 && !hold) check("rd_en_fall", 32'(m_wr_en), 32'(0));
      @(negedge clk);
    end
    check("rd_mv_cycles", 32'(mv_cnt), 32'(17));
    check("rd_sv_cycles", 32'(sv_cnt), 32'(8));
    check("rd_bus_bits", 32'(gr), 32'(exp));
    check("rd_data_held", 32'(m_rd_data), 32'(exp));
    check("rd_en_end", 32'(m_wr_en), 32'(hold));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    last_rd = 8'h00;

    // Basic write then read-with-start-held.
    run_write(16'h1234, 8'hA5, last_rd);
    run_read(16'h1234, 8'hA5, 1'b1);
    last_rd = 8'hA5;

    // Mode change while still in HOLD is accepted without dropping start.
    run_write(16'h0567, 8'h5A, last_rd);
    run_read(16'h0567, 8'h5A, 1'b0);
    last_rd = 8'h5A;

    // Upper address bits are ignored: F234 aliases 1234.
    run_read(16'hF234, 8'hA5, 1'b0);
    last_rd = 8'hA5;

    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rd = 8'($urandom_range(0, 255));
      run_write(ra, rd, last_rd);
      repeat (10) @(negedge clk);
      run_read(ra, rd, 1'b0);
      last_rd = rd;
    end

    // Reset in the middle of the address phase aborts a write.
    run_write(16'h0ABC, 8'h3C, last_rd);
    @(negedge clk);
    m_start = 1'b1; m_mode = 1'b1; m_addr = 16'h0ABC; m_wr_data = 8'hC3;
    @(negedge clk);
    m_start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    last_rd = 8'h00;
    run_read(16'h0ABC, 8'h3C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "time limit");
  end
endmodule
